// File: rtl/addsub_serial.sv
// Chunk-serial adder/subtractor with valid/ready request and valid/ack result handshakes.
// Define ADDSUB_SAT_EN to clamp S to the signed range on overflow; otherwise S wraps.
module addsub_serial #(
  parameter int DATA_SIZE = 32,
  parameter int CHUNK     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DATA_SIZE-1:0] X,
  input  logic [DATA_SIZE-1:0] Y,
  input  logic                 Cin,
  output logic                 o_valid,
  input  logic                 i_ack,
  output logic [DATA_SIZE-1:0] S,
  output logic                 Co,
  output logic                 V,
  output logic                 Z
);

  // state | meaning
  // IDLE  | waiting for a request, o_ready high
  // CALC  | adding one CHUNK slice per cycle, LSB slice first
  // DONE  | result valid, held until i_ack
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int NCHUNK = DATA_SIZE / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d, s_q, s_d;
  logic                 carry_q, carry_d, x_msb_q, x_msb_d, y_msb_q, y_msb_d;
  logic                 co_q, co_d, v_q, v_d, z_q, z_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [CHUNK:0]       slice_sum;
  logic [DATA_SIZE-1:0] sum_full, s_fin;
  logic                 v_fin, last, accept;

  assign slice_sum = {1'b0, x_q[CHUNK-1:0]} + {1'b0, y_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};

  // Slice sums enter at the top of acc and shift down, so after NCHUNK cycles
  // the slices sit in their natural positions.
  generate
    if (NCHUNK > 1) begin : g_multi
      assign sum_full = {slice_sum[CHUNK-1:0], acc_q[DATA_SIZE-1:CHUNK]};
    end else begin : g_single
      assign sum_full = slice_sum[CHUNK-1:0];
    end
  endgenerate

  // Same-sign operands producing an opposite-sign sum is exactly
  // carry-into-MSB xor carry-out-of-MSB.
  assign v_fin = (x_msb_q == y_msb_q) && (sum_full[DATA_SIZE-1] != x_msb_q);
  assign last  = (cnt_q == CW'(NCHUNK - 1));

`ifdef ADDSUB_SAT_EN
  assign s_fin = !v_fin ? sum_full :
                 x_msb_q ? {1'b1, {(DATA_SIZE-1){1'b0}}} : {1'b0, {(DATA_SIZE-1){1'b1}}};
`else
  assign s_fin = sum_full;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      x_msb_q <= 1'b0;
      y_msb_q <= 1'b0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      x_msb_q <= x_msb_d;
      y_msb_q <= y_msb_d;
      co_q    <= co_d;
      v_q     <= v_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    s_d     = s_q;
    carry_d = carry_q;
    x_msb_d = x_msb_q;
    y_msb_d = y_msb_q;
    co_d    = co_q;
    v_d     = v_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        accept  = i_valid;
      end
      CALC: begin
        x_d     = x_q >> CHUNK;
        y_d     = y_q >> CHUNK;
        acc_d   = sum_full;
        carry_d = slice_sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          s_d     = s_fin;
          co_d    = slice_sum[CHUNK];
          v_d     = v_fin;
          z_d     = (s_fin == '0);
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ack) begin
          o_ready = 1'b1;
          state_d = IDLE;
          accept  = i_valid;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accepting from DONE+ack overrides the return to IDLE, so there is no bubble.
    if (accept) begin
      state_d = CALC;
      x_d     = X;
      y_d     = Y ^ {DATA_SIZE{Cin}};
      carry_d = Cin;
      cnt_d   = '0;
      x_msb_d = X[DATA_SIZE-1];
      y_msb_d = Y[DATA_SIZE-1] ^ Cin;
    end
  end

  assign S  = s_q;
  assign Co = co_q;
  assign V  = v_q;
  assign Z  = z_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (DATA_SIZE=32, CHUNK=8): fixed vectors,
// handshake corner sequences and random operations against an arithmetic model.
module tb_addsub_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, Cin, o_valid, i_ack, Co, V, Z;
  logic [31:0] X, Y, S;

  int n_vec = 0;
  int n_err = 0;

  addsub_serial #(.DATA_SIZE(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .X(X), .Y(Y), .Cin(Cin), .o_valid(o_valid), .i_ack(i_ack),
    .S(S), .Co(Co), .V(V), .Z(Z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic [31:0] s;
    logic        co;
    logic        v;
    logic        z;
  } vec_t;

  vec_t tbl[10];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Signed-range reference: overflow is judged on the true integer result.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic cin,
                                output logic [31:0] s, output logic co, output logic v,
                                output logic z);
    logic [32:0] full;
    longint      sx, sy, r;
    full = {1'b0, x} + {1'b0, (cin ? ~y : y)} + 33'(cin);
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    r    = cin ? (sx - sy) : (sx + sy);
    v    = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    co   = full[32];
    s    = full[31:0];
`ifdef ADDSUB_SAT_EN
    if (v) s = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    z = (s == 32'h0);
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic cin);
    i_valid = 1'b1;
    X = x;
    Y = y;
    Cin = cin;
    #1;
    chk1("ready_before_accept", o_ready, 1'b1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    X = $urandom;
    Y = $urandom;
    Cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!o_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk32({name, "_latency"}, 32'(n), 32'd4);
  endtask

  task automatic check_res(input string name, input logic [31:0] s, input logic co,
                           input logic v, input logic z);
    chk32({name, "_S"}, S, s);
    chk1({name, "_Co"}, Co, co);
    chk1({name, "_V"}, V, v);
    chk1({name, "_Z"}, Z, z);
  endtask

  task automatic ack_op();
    i_ack = 1'b1;
    @(posedge clk);
    #1;
    i_ack = 1'b0;
    chk1("valid_drop_after_ack", o_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] es;
    logic        eco, ev, ez;
    logic [31:0] keep_s;
    logic        keep_co, keep_v, keep_z;
    int          seen;

    tbl[0] = '{32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{32'd5, 32'd5, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{32'h0000_00FF, 32'd1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{32'h00FF_FFFF, 32'd1, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SAT_EN
    tbl[6] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
    tbl[6] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1};
`endif
    tbl[9] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h0246_8ACF, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    i_valid = 1'b0;
    i_ack = 1'b0;
    X = '0;
    Y = '0;
    Cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_res("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    chk1("reset_valid", o_valid, 1'b0);
    chk1("reset_ready", o_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      start_op(tbl[i].x, tbl[i].y, tbl[i].cin);
      wait_valid($sformatf("tbl%0d", i));
      check_res($sformatf("tbl%0d", i), tbl[i].s, tbl[i].co, tbl[i].v, tbl[i].z);
      ack_op();
    end

    // Result held while unacknowledged; noisy inputs must not be accepted.
    start_op(32'd100, 32'd23, 1'b1);
    wait_valid("hold");
    keep_s = S; keep_co = Co; keep_v = V; keep_z = Z;
    chk32("hold_first_S", S, 32'd77);
    for (int i = 0; i < 10; i++) begin
      i_valid = ~i_valid;
      X = $urandom;
      Y = $urandom;
      Cin = ~Cin;
      #1;
      chk1("hold_valid", o_valid, 1'b1);
      chk1("hold_ready", o_ready, 1'b0);
      chk32("hold_S", S, 32'd77);
      chk1("hold_flags", (Co == keep_co) && (V == keep_v) && (Z == keep_z), 1'b1);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    ack_op();
    chk1("hold_idle_ready", o_ready, 1'b1);
    chk32("hold_retained_S", S, keep_s);

    // Back-to-back: ack and new request on the same edge.
    start_op(32'd7, 32'd9, 1'b0);
    wait_valid("b2b_first");
    chk32("b2b_first_S", S, 32'd16);
    i_ack = 1'b1;
    i_valid = 1'b1;
    X = 32'd1;
    Y = 32'd1;
    Cin = 1'b0;
    #1;
    chk1("b2b_ready", o_ready, 1'b1);
    @(posedge clk);
    #1;
    i_ack = 1'b0;
    i_valid = 1'b0;
    X = $urandom;
    Y = $urandom;
    chk1("b2b_busy_valid", o_valid, 1'b0);
    chk1("b2b_busy_ready", o_ready, 1'b0);
    chk32("b2b_retained_S", S, 32'd16);
    wait_valid("b2b_second");
    check_res("b2b_second", 32'd2, 1'b0, 1'b0, 1'b0);
    ack_op();

    // Reset in the second CALC cycle discards the operation.
    start_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_res("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0);
    chk1("rst_mid_valid", o_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("rst_after_ready", o_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (o_valid) seen++;
    end
    chk32("rst_no_stale_valid", 32'(seen), 32'd0);
    chk32("rst_S_stays_zero", S, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] rx, ry;
      logic        rc;
      case ($urandom_range(0, 4))
        0: rx = 32'h7FFF_FFFF;
        1: rx = 32'h8000_0000;
        default: rx = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: ry = 32'hFFFF_FFFF;
        1: ry = 32'h8000_0000;
        default: ry = $urandom;
      endcase
      rc = 1'($urandom_range(0, 1));
      model(rx, ry, rc, es, eco, ev, ez);
      start_op(rx, ry, rc);
      wait_valid($sformatf("rnd%0d", i));
      check_res($sformatf("rnd%0d", i), es, eco, ev, ez);
      ack_op();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
